// File: rtl/cache_pkg.sv
// Shared constants for the cache memory side: line/address widths,
// responder state encoding and the default response latency.
package cache_pkg;

  localparam int LINE_W          = 128;
  localparam int MEM_ADDR_W      = 28;
  localparam int DEFAULT_LATENCY = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY    = 2'd1;
  localparam logic [1:0] ST_RESPOND = 2'd2;

endpackage

// File: rtl/cache_mem_responder_if.sv
// Cache-to-memory line handshake; the cache is the master, the backing store the slave.
interface cache_mem_responder_if;
  import cache_pkg::*;

  logic                  mem_read;
  logic                  mem_write;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0]     mem_wdata;
  logic [LINE_W-1:0]     mem_rdata;
  logic                  mem_ready;

  modport master (output mem_read, mem_write, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ready);
  modport slave  (input  mem_read, mem_write, mem_addr, mem_wdata,
                  output mem_rdata, mem_ready);

endinterface

// File: rtl/cache_line_ram.sv
// Single-port line store: synchronous write, registered read. Only the read
// register is reset; the array keeps its contents across reset.
module cache_line_ram
  import cache_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] lines [2**ADDR_W];
  logic [LINE_W-1:0] rdata_q, rdata_d;

  // Read register holds its value except on a read strobe.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = lines[addr];
  end

  always_ff @(posedge clk) begin
    if (proc_reset) rdata_q <= '0;
    else            rdata_q <= rdata_d;
  end

  always_ff @(posedge clk) begin
    if (we) lines[addr] <= wdata;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cache_mem_responder.sv
// Latency-programmable memory responder for the cache line interface,
// with saturating read/write counters and a sticky protocol-error flag.
module cache_mem_responder
  import cache_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 proc_reset,
  cache_mem_responder_if.slave bus,
  output logic [CNT_W-1:0]     rd_count,
  output logic [CNT_W-1:0]     wr_count,
  output logic                 proto_err
);

  logic [1:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              op_wr_q, op_wr_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic [CNT_W-1:0]  rd_count_q, rd_count_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;
  logic              proto_err_q, proto_err_d;
  logic              ram_we, ram_re;
  logic              unused_addr_bits;

  // Upper address bits alias onto the array.
  assign unused_addr_bits = ^bus.mem_addr[MEM_ADDR_W-1:ADDR_W];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_wr_d     = op_wr_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    ready_d     = 1'b0;
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;
    proto_err_d = proto_err_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.mem_read && bus.mem_write) begin
          proto_err_d = 1'b1;
        end else if (bus.mem_read || bus.mem_write) begin
          op_wr_d = bus.mem_write;
          idx_d   = bus.mem_addr[ADDR_W-1:0];
          wdata_d = bus.mem_wdata;
          cnt_d   = 8'(LATENCY - 1);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 8'd0) begin
          // Commit/fetch on the edge entering RESPOND so writes land before ready.
          ram_we  = op_wr_q && !proc_reset;
          ram_re  = !op_wr_q;
          ready_d = 1'b1;
          state_d = ST_RESPOND;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RESPOND: begin
        if (op_wr_q) begin
          if (wr_count_q != '1) wr_count_d = wr_count_q + 1'b1;
        end else begin
          if (rd_count_q != '1) rd_count_d = rd_count_q + 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_wr_q     <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      ready_q     <= 1'b0;
      rd_count_q  <= '0;
      wr_count_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_wr_q     <= op_wr_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
      proto_err_q <= proto_err_d;
    end
  end

  cache_line_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk        (clk),
    .proc_reset (proc_reset),
    .we         (ram_we),
    .re         (ram_re),
    .addr       (idx_q),
    .wdata      (wdata_q),
    .rdata      (bus.mem_rdata)
  );

  assign bus.mem_ready = ready_q;
  assign rd_count      = rd_count_q;
  assign wr_count      = wr_count_q;
  assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: latency, data, aliasing,
// protocol error and reset-during-transaction behaviour.
module tb_cache_mem_responder;
  import cache_pkg::*;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             proc_reset;
  logic [CNT_W-1:0] rd_count, wr_count;
  logic             proto_err;
  int               n_checks = 0;
  int               n_errors = 0;

  localparam logic [127:0] DATA_A = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] DATA_B = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] DATA_C = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;

  cache_mem_responder_if mif ();

  cache_mem_responder #(.ADDR_W(8), .LATENCY(4), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .bus        (mif.slave),
    .rd_count   (rd_count),
    .wr_count   (wr_count),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, hold it until mem_ready, return cycles-to-ready and data.
  task automatic req(input logic wr, input logic [27:0] addr, input logic [127:0] wd,
                     output int lat, output logic [127:0] rd);
    mif.mem_read  = !wr;
    mif.mem_write = wr;
    mif.mem_addr  = addr;
    mif.mem_wdata = wd;
    lat = -1;
    rd  = '0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (mif.mem_ready) begin
        lat = n;
        rd  = mif.mem_rdata;
        break;
      end
    end
    mif.mem_read  = 1'b0;
    mif.mem_write = 1'b0;
  endtask

  int           lat;
  logic [127:0] rd;
  int           pulses;

  initial begin
    mif.mem_read  = 1'b0;
    mif.mem_write = 1'b0;
    mif.mem_addr  = '0;
    mif.mem_wdata = '0;
    proc_reset    = 1'b1;
    step();
    step();
    proc_reset = 1'b0;

    // 1: idle after reset
    chk("reset_rdata", mif.mem_rdata, '0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_ready", {127'd0, mif.mem_ready}, '0);
      chk("idle_cnts", {rd_count, wr_count}, '0);
      chk("idle_err", {127'd0, proto_err}, '0);
    end

    // 2: write latency and single pulse
    req(1'b1, 28'h0000013, DATA_A, lat, rd);
    chk("wr_latency", 128'(lat), 128'd5);
    step();
    chk("wr_pulse_end", {127'd0, mif.mem_ready}, '0);
    chk("wr_count1", 128'(wr_count), 128'd1);
    chk("wr_rdata_kept", mif.mem_rdata, '0);

    // 3: read back, no re-trigger
    req(1'b0, 28'h0000013, 128'd0, lat, rd);
    chk("rd_latency", 128'(lat), 128'd5);
    chk("rd_data", rd, DATA_A);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (mif.mem_ready) pulses++;
    end
    chk("rd_no_retrigger", 128'(pulses), 128'd0);
    chk("rd_count1", 128'(rd_count), 128'd1);
    chk("rd_data_held", mif.mem_rdata, DATA_A);

    // 4: aliasing of upper address bits
    req(1'b1, 28'h0000105, DATA_B, lat, rd);
    step();
    req(1'b0, 28'h0000005, 128'd0, lat, rd);
    chk("alias_data", rd, DATA_B);
    step();
    chk("alias_cnts", {rd_count, wr_count}, {CNT_W'(2), CNT_W'(2)});

    // 5: protocol error
    mif.mem_read  = 1'b1;
    mif.mem_write = 1'b1;
    mif.mem_addr  = 28'h0000013;
    step();
    chk("proto_set", {127'd0, proto_err}, 128'd1);
    step();
    step();
    mif.mem_read  = 1'b0;
    mif.mem_write = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (mif.mem_ready) pulses++;
    end
    chk("proto_no_ready", 128'(pulses), 128'd0);
    chk("proto_sticky", {127'd0, proto_err}, 128'd1);
    chk("proto_cnts", {rd_count, wr_count}, {CNT_W'(2), CNT_W'(2)});

    // 6: reset in 2nd BUSY cycle discards the write
    mif.mem_write = 1'b1;
    mif.mem_addr  = 28'h0000013;
    mif.mem_wdata = DATA_C;
    pulses = 0;
    step();
    if (mif.mem_ready) pulses++;
    step();
    if (mif.mem_ready) pulses++;
    proc_reset    = 1'b1;
    mif.mem_write = 1'b0;
    step();
    proc_reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (mif.mem_ready) pulses++;
    end
    chk("rst_no_ready", 128'(pulses), 128'd0);
    chk("rst_cnts", {rd_count, wr_count}, '0);
    chk("rst_err_clr", {127'd0, proto_err}, '0);
    chk("rst_rdata", mif.mem_rdata, '0);
    req(1'b0, 28'h0000013, 128'd0, lat, rd);
    chk("rst_old_data", rd, DATA_A);
    chk("rst_rd_latency", 128'(lat), 128'd5);
    step();
    chk("rst_rd_count", 128'(rd_count), 128'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cache_mem_responder.md
Name: cache_mem_responder

Overview:
- Block-memory responder for the cache's 128-bit memory interface: the far end of the mem_read/mem_write/mem_addr/mem_wdata to mem_rdata/mem_ready handshake.
- Holds a parameterised array of 128-bit lines, answers each request after a programmable latency, and keeps read/write/protocol-error counters.
- Serves as the memory model in cache benches and as the synthesizable on-chip backing store behind the cache.

Parameters:
- ADDR_W, 8: line-index bits used from mem_addr; depth = 2**ADDR_W lines of 128 bits.
- LATENCY, 4: cycles spent in BUSY before the response; legal range 1..255.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  rising-edge clock.
- proc_reset  in  1  synchronous, active-high reset.
- mem_read  in  1  read request; held high until mem_ready is seen.
- mem_write  in  1  write request; held high until mem_ready is seen.
- mem_addr  in  28  line address; bits [ADDR_W-1:0] index the array, upper bits ignored (aliasing).
- mem_wdata  in  128  write line; stable while mem_write is high.
- mem_rdata  out  128  read line; valid in the mem_ready cycle of a read.
- mem_ready  out  1  single-cycle completion pulse.
- rd_count  out  CNT_W  completed reads; saturating.
- wr_count  out  CNT_W  completed writes; saturating.
- proto_err  out  1  sticky; set when mem_read and mem_write are both high in IDLE.

Behaviour:
- One clock (clk); reset is synchronous and active-high (proc_reset). All outputs are registered.
- Reset values: state=IDLE, mem_ready=0, mem_rdata=0, rd_count=0, wr_count=0, proc_err=0, latency counter=0.
- Array contents are not affected by reset. The simulation model initialises the array to all-zero.
- FSM states: IDLE, BUSY, RESPOND.
- IDLE:
  - Exactly one of mem_read/mem_write high: capture op, addr index and wdata; load counter with LATENCY-1; go to BUSY.
  - Both high: set proto_err; capture nothing; stay in IDLE.
  - Neither high: stay in IDLE.
- BUSY:
  - Counter decrements each cycle.
  - Counter==0: go to RESPOND and register mem_ready=1.
  - Read: mem_rdata <= array[idx] on the same edge.
  - Write: array[idx] <= captured wdata on the same edge.
  - Request inputs are not sampled in BUSY. Captured values are used even if the inputs change.
- RESPOND:
  - mem_ready=1 for exactly this one cycle; rd_count or wr_count increments (saturates at all-ones).
  - Next state is always IDLE; mem_ready returns to 0.
  - The initiator drops its request on the edge leaving RESPOND. IDLE therefore sees the request low, and no duplicate transaction is started.
- Latency: request first high in IDLE cycle t; BUSY covers cycles t+1..t+LATENCY; mem_ready high in cycle t+LATENCY+1.
- mem_rdata holds its last read value outside read responses; writes do not change it.
- Ordering: a write commits before its mem_ready. A read issued after it (e.g. writeback then allocate to the same line) returns the new data.
- Reset during BUSY or RESPOND: return to IDLE and drop mem_ready. A write not yet committed (still in BUSY) is discarded; a write already committed stays.
- Back-to-back requests: minimum spacing is 1 IDLE cycle between responses.

Decomposition:
- Shared package cache_pkg holds:
  - line width (128) and mem address width (28);
  - responder state encoding (IDLE=2'd0, BUSY=2'd1, RESPOND=2'd2);
  - default LATENCY.
- One natural sub-module, cache_line_ram: single-port 2**ADDR_W x 128 array with synchronous write and registered read. The FSM, counters and error flag stay in the top.

Test Plan:
1. Reset with LATENCY=4, then hold idle 10 cycles -> mem_ready=0, rd_count=0, wr_count=0, proto_err=0 throughout.
2. Write mem_addr=28'h0000013, mem_wdata=128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, held until ready -> mem_ready high exactly 5 cycles after the request's first IDLE cycle, for 1 cycle; wr_count=1.
3. Read the same address next -> mem_rdata=128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D in the mem_ready cycle; rd_count=1; exactly one pulse, no re-trigger.
4. Write addr 28'h0000105 then read addr 28'h0000005 with ADDR_W=8 -> read returns the written line (aliasing).
5. mem_read=mem_write=1 in IDLE -> proto_err=1 and stays 1; no mem_ready; counters unchanged.
6. Write issued, proc_reset asserted in its 2nd BUSY cycle, then read of the same addr -> no mem_ready for the write; read returns the old contents.
